mem_port_arbiter: RTL and testbench

- Shares one single-port 256x16 unified memory between the processor's instruction-fetch port and its load/store port.
- Sits between the Processor and the memory model.
- Serialises fetch, load and store requests through one downstream req/ack handshake, with load/store priority and a fetch anti-starvation limit.
- Returns data and completion pulses on each port, and times out accesses the memory never acknowledges.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_arb_priority.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    // Defaults shared with the processor's memory interface
    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_LS    = 1'b1
    } arb_src_e;

    // Winner of one arbitration round
    typedef struct packed {
        logic     valid;
        arb_src_e src;
        logic     we;
    } arb_grant_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and load/store, with a saturating counter
// that forces a fetch grant after STARVE_MAX load/store grants in a row.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       grant_en_i,
    input  logic       fetch_req_i,
    input  logic       ls_read_req_i,
    input  logic       ls_write_req_i,
    output arb_grant_t grant_o
);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_fetch;

    // Combinational winner; read+write together resolves to a write
    always_comb begin
        grant_o     = '0;
        force_fetch = fetch_req_i && (starve_cnt_q == CNT_W'(STARVE_MAX));
        if (force_fetch) begin
            grant_o.valid = 1'b1;
            grant_o.src   = SRC_FETCH;
        end else if (ls_read_req_i || ls_write_req_i) begin
            grant_o.valid = 1'b1;
            grant_o.src   = SRC_LS;
            grant_o.we    = ls_write_req_i;
        end else if (fetch_req_i) begin
            grant_o.valid = 1'b1;
            grant_o.src   = SRC_FETCH;
        end
    end

    // Counter only moves on an actual grant; a waiting fetch makes it climb
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_en_i && grant_o.valid) begin
            if (grant_o.src == SRC_FETCH || !fetch_req_i)
                starve_cnt_d = '0;
            else if (starve_cnt_q != CNT_W'(STARVE_MAX))
                starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!rst) starve_cnt_q <= '0;
        else      starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction at a time: IDLE arbitrates, ACCESS holds the downstream
// request until ack or timeout, RESP emits the completion pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_valid,
    input  logic              ls_read_req,
    input  logic              ls_write_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_value_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam int TMO_W = 4;

    arb_state_e        state_q, state_d;
    arb_src_e          src_q, src_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic              tmo_expire;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_value_ready_q, ls_value_ready_d;
    logic              timeout_err_q, timeout_err_d;
    arb_grant_t        grant;

    mem_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk            (clk),
        .rst            (rst),
        .grant_en_i     (state_q == ST_IDLE),
        .fetch_req_i    (fetch_req),
        .ls_read_req_i  (ls_read_req),
        .ls_write_req_i (ls_write_req),
        .grant_o        (grant)
    );

    // Expiry is judged on the incremented count so ACCESS lasts TIMEOUT cycles
    assign tmo_inc    = tmo_cnt_q + 1'b1;
    assign tmo_expire = (tmo_inc == TMO_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; an ack in the expiry cycle still wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant.valid) state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ack || tmo_expire) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; pulses default low, everything else holds
    always_comb begin
        src_d            = src_q;
        tmo_cnt_d        = tmo_cnt_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        fetch_instr_d    = fetch_instr_q;
        fetch_valid_d    = 1'b0;
        ls_rdata_d       = ls_rdata_q;
        ls_value_ready_d = 1'b0;
        timeout_err_d    = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (grant.valid) begin
                    src_d     = grant.src;
                    mem_req_d = 1'b1;
                    mem_we_d  = grant.we;
                    if (grant.src == SRC_FETCH) begin
                        mem_addr_d  = fetch_addr;
                        mem_wdata_d = '0;
                    end else begin
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                tmo_cnt_d = tmo_inc;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (src_q == SRC_FETCH) begin
                        fetch_instr_d = mem_rdata;
                        fetch_valid_d = 1'b1;
                    end else begin
                        ls_value_ready_d = 1'b1;
                        if (!mem_we_q) ls_rdata_d = mem_rdata;
                    end
                end else if (tmo_expire) begin
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    if (src_q == SRC_FETCH) begin
                        fetch_instr_d = '0;
                        fetch_valid_d = 1'b1;
                    end else begin
                        ls_rdata_d       = '0;
                        ls_value_ready_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q            <= SRC_FETCH;
            tmo_cnt_q        <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            fetch_instr_q    <= '0;
            fetch_valid_q    <= 1'b0;
            ls_rdata_q       <= '0;
            ls_value_ready_q <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            src_q            <= src_d;
            tmo_cnt_q        <= tmo_cnt_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            fetch_instr_q    <= fetch_instr_d;
            fetch_valid_q    <= fetch_valid_d;
            ls_rdata_q       <= ls_rdata_d;
            ls_value_ready_q <= ls_value_ready_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign fetch_instr    = fetch_instr_q;
    assign fetch_valid    = fetch_valid_q;
    assign ls_rdata       = ls_rdata_q;
    assign ls_value_ready = ls_value_ready_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus multi-cycle
// sequences for starvation, timeout and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic [15:0] fetch_instr;
    logic        fetch_valid;
    logic        ls_read_req;
    logic        ls_write_req;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic [15:0] ls_rdata;
    logic        ls_value_ready;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_instr    (fetch_instr),
        .fetch_valid    (fetch_valid),
        .ls_read_req    (ls_read_req),
        .ls_write_req   (ls_write_req),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_rdata       (ls_rdata),
        .ls_value_ready (ls_value_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .timeout_err    (timeout_err)
    );

    // Memory model: acks in the first ACCESS cycle when enabled, logs grants
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [15:0] wdata;
    } gnt_t;

    logic [15:0] mem [0:255];
    logic        ack_en = 1'b1;
    logic        req_prev = 1'b0;
    gnt_t        glog[$];

    always @(negedge clk) begin
        if (mem_req && !req_prev) glog.push_back('{mem_we, mem_addr, mem_wdata});
        req_prev = mem_req;
        if (mem_req && ack_en && !mem_ack) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                mem_rdata = 16'hDEAD;
            end else begin
                mem_rdata = mem[mem_addr];
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'h0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f, rd, wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wdata;
        logic        exp_fpulse;
        logic [15:0] exp_data;
    } vec_t;

    // Called at a negedge with the FSM in IDLE; returns at a negedge in IDLE
    task automatic run_vec(input string tag, input vec_t v);
        int waited;
        logic seen_f, seen_l;
        glog.delete();
        fetch_req    = v.f;
        fetch_addr   = v.f ? v.addr : 8'hFF;
        ls_read_req  = v.rd;
        ls_write_req = v.wr;
        ls_addr      = v.f ? 8'h00 : v.addr;
        ls_wdata     = v.wdata;
        waited = 0;
        seen_f = 1'b0;
        seen_l = 1'b0;
        while (!seen_f && !seen_l && waited < 40) begin
            @(negedge clk);
            waited++;
            seen_f = fetch_valid;
            seen_l = ls_value_ready;
        end
        fetch_req    = 1'b0;
        ls_read_req  = 1'b0;
        ls_write_req = 1'b0;
        // request cycle + ACCESS + RESP = 3 cycles, i.e. pulse 2 edges later
        chk({tag, " latency"}, waited, 2);
        chk({tag, " fetch_valid"}, seen_f, v.exp_fpulse);
        chk({tag, " ls_value_ready"}, seen_l, !v.exp_fpulse);
        chk({tag, " data"}, v.exp_fpulse ? fetch_instr : ls_rdata, v.exp_data);
        chk({tag, " grants"}, glog.size(), 1);
        if (glog.size() > 0) begin
            chk({tag, " mem_we"}, glog[0].we, v.exp_we);
            chk({tag, " mem_addr"}, glog[0].addr, v.exp_addr);
            if (v.exp_we) chk({tag, " mem_wdata"}, glog[0].wdata, v.exp_wdata);
        end
        @(negedge clk);
        chk({tag, " pulse_width"}, {fetch_valid, ls_value_ready}, 2'b00);
    endtask

    vec_t vecs[6];
    logic [7:0] starve_exp[6];

    initial begin
        int cyc, reqc, pulses, reqs_after;
        logic seen;

        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        mem[8'h01] = 16'hE801;

        //            f     rd    wr    addr   wdata     we    eaddr  ewdata    fpul  data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b1, 16'hE801};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h82, 16'h00AB, 1'b1, 8'h82, 16'h00AB, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h82, 16'h0000, 1'b0, 8'h82, 16'h0000, 1'b0, 16'h00AB};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h80, 16'h0005, 1'b1, 8'h80, 16'h0005, 1'b0, 16'h00AB};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h80, 16'h0000, 1'b0, 8'h80, 16'h0000, 1'b0, 16'h0005};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h82, 16'h0000, 1'b0, 8'h82, 16'h0000, 1'b1, 16'h00AB};

        starve_exp[0] = 8'h20; starve_exp[1] = 8'h20; starve_exp[2] = 8'h20;
        starve_exp[3] = 8'h20; starve_exp[4] = 8'h10; starve_exp[5] = 8'h20;

        rst = 1'b0;
        fetch_req = 1'b0; fetch_addr = 8'h00;
        ls_read_req = 1'b0; ls_write_req = 1'b0; ls_addr = 8'h00; ls_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset fetch_valid", fetch_valid, 0);
        chk("reset ls_value_ready", ls_value_ready, 0);
        chk("reset fetch_instr", fetch_instr, 0);
        chk("reset ls_rdata", ls_rdata, 0);
        chk("reset timeout_err", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Starvation: fetch held against continuous loads
        glog.delete();
        fetch_req = 1'b1; fetch_addr = 8'h10;
        ls_read_req = 1'b1; ls_addr = 8'h20;
        cyc = 0;
        while (glog.size() < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (fetch_valid) fetch_req = 1'b0;
        end
        ls_read_req = 1'b0;
        fetch_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("starve grant_count", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve grant%0d addr", i),
                (i < glog.size()) ? 32'(glog[i].addr) : 32'hFFFFFFFF, 32'(starve_exp[i]));
        chk("starve fetch_instr", fetch_instr, 16'hC010);

        // Timeout: memory never acks a load
        ack_en = 1'b0;
        ls_read_req = 1'b1; ls_addr = 8'h30;
        cyc = 0; reqc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) reqc++;
            seen = ls_value_ready;
        end
        ls_read_req = 1'b0;
        chk("timeout req_cycles", reqc, 15);
        chk("timeout pulse", seen, 1);
        chk("timeout ls_rdata", ls_rdata, 0);
        chk("timeout err", timeout_err, 1);
        chk("timeout no fetch_valid", fetch_valid, 0);
        @(negedge clk);
        ack_en = 1'b1;
        run_vec("post_timeout", '{1'b0, 1'b1, 1'b0, 8'h82, 16'h0000, 1'b0, 8'h82, 16'h0000, 1'b0, 16'h00AB});
        chk("timeout err sticky", timeout_err, 1);

        // Reset in the middle of an unacknowledged fetch
        ack_en = 1'b0;
        fetch_req = 1'b1; fetch_addr = 8'h40;
        repeat (3) @(negedge clk);
        chk("midrst access active", mem_req, 1);
        rst = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("midrst mem_req", mem_req, 0);
        chk("midrst mem_addr", mem_addr, 0);
        chk("midrst fetch_instr", fetch_instr, 0);
        chk("midrst ls_rdata", ls_rdata, 0);
        chk("midrst timeout_err", timeout_err, 0);
        chk("midrst pulses", {fetch_valid, ls_value_ready}, 2'b00);
        rst = 1'b1;
        ack_en = 1'b1;
        pulses = 0; reqs_after = 0;
        repeat (5) begin
            @(negedge clk);
            if (fetch_valid || ls_value_ready) pulses++;
            if (mem_req) reqs_after++;
        end
        chk("midrst no pulse", pulses, 0);
        chk("midrst no resume", reqs_after, 0);
        run_vec("post_reset", '{1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b1, 16'hE801});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
